mac_accumulator: RTL and testbench
==================================

// Module: mac_accumulator
// PURPOSE
//  Downstream of the array logic stage. Consumes the 16 per-bank 8-bit partial
//  products (add0..add15) and runs a pipelined adder tree. In MAC mode it then
//  shift-accumulates ACT_BITS bit-serial activation planes, LSB first. In search
//  mode it sums one plane of match bits, giving a match count.
//  Tells the upstream controller which plane to drive, and returns one result
//  per operation over a valid/ready handshake.
// PARAMETERS
//  NUM_BANK   16  number of bank partial-product inputs (fixed at 16 by the port list)
//  IN_W       8   width of each addN input
//  ACT_BITS   8   activation bit-planes per MAC operation
//  ACT_SIGNED 0   1: MSB plane has negative weight (two's-complement activation)
//  ACC_W      20  result width; IN_W+log2(NUM_BANK)+ACT_BITS, overflow-free
// PORTS
//  clk_inv       in   1      clock; all flops rising-edge on clk_inv
//  rst           in   1      asynchronous, active-high reset
//  start         in   1      begin operation; accepted only in IDLE
//  mac_en        in   1      mode, captured at start: 1 = MAC, 0 = search
//  add0..add15   in   IN_W   per-bank partial products or {7'd0,match}
//  plane_idx     out  3      activation plane upstream must drive into data_in
//  busy          out  1      high from accepted start until handshake completes
//  result        out  ACC_W  accumulated sum; signed when ACT_SIGNED=1
//  result_valid  out  1      result is stable and valid
//  result_ready  in   1      consumer accepts result
// BEHAVIOUR
//  Reset values: plane_idx=0, busy=0, result=0, result_valid=0; internal
//  tree register, accumulator, plane counters and FSM cleared. Reset is honoured
//  mid-operation: the partial result is discarded and no result_valid follows.
//  FSM:
//   - IDLE -> FILL on start. Same edge: latch mode, set N (ACT_BITS if MAC, else 1),
//     clear accumulator, plane_idx=0.
//   - FILL: edges E1..EN register the tree sum of plane p=E-1; plane_idx
//     increments after each edge and saturates at N-1.
//   - FILL -> DRAIN after plane N-1 is registered.
//   - DRAIN: one edge adds the last plane. Then result_valid=1, state HOLD.
//   - HOLD -> IDLE on the edge where result_valid && result_ready; result_valid
//     drops after that edge.
//  Latency: start sampled at E0; result_valid rises after E(N+1), i.e. 9 cycles
//   in MAC mode and 2 in search mode.
//  Arithmetic:
//   - tree sum: zero-extended 12-bit sum of the 16 inputs, max 4080.
//   - accumulate: acc += sum << p for every plane, except acc -= sum << p when
//     ACT_SIGNED=1, mac mode and p=ACT_BITS-1.
//   - search mode never subtracts.
//  result: driven from the accumulator register. Held stable while
//   result_valid && !result_ready.
//  Ignored inputs:
//   - start outside IDLE, including the handshake cycle; no queuing.
//   - mac_en except at an accepted start.
//  busy covers FILL, DRAIN and HOLD.
// STRUCTURE
//  Shared header cella_defines.vh: NUM_BANK, IN_W, ACT_BITS, ACC_W, FSM state
//   encodings (IDLE/FILL/DRAIN/HOLD).
//  Sub-module adder_tree16: 16 x IN_W -> IN_W+4 adder tree with one output
//   register and async clear. The accumulator, plane counter and FSM stay in
//   this module.
// TESTING
//  1 search: mac_en=0, start, add0..add4={7'd0,1'b1}, others 0
//    -> result=5, result_valid 2 cycles after start.
//  2 MAC unsigned: all addN=8'hFF on all 8 planes
//    -> result=20'hFE010 (1,040,400), valid 9 cycles after start.
//  3 MAC signed (ACT_SIGNED=1): add0=8'd10 only on plane 7, all else 0
//    -> result=20'hFFB00 (-1280).
//  4 backpressure: result_ready low 5 cycles after valid, start pulsed meanwhile
//    -> result stable, busy=1, start ignored; ready=1 -> IDLE next edge.
//  5 reset mid-op: rst pulsed at plane_idx=3 -> all outputs 0 immediately, no
//    result_valid; a following test-2 operation still gives 20'hFE010.
//  6 start re-pulsed during FILL -> ignored; plane_idx sequence 0..7 unchanged.

Source files
------------

// File: rtl/mac_accumulator_pkg.sv
// Shared constants and FSM state type for the MAC / match-count accumulator.
package mac_accumulator_pkg;

  localparam int unsigned NUM_BANK = 16;
  localparam int unsigned IN_W     = 8;
  localparam int unsigned ACT_BITS = 8;
  // Tree sum of 16 x IN_W values needs 4 extra bits.
  localparam int unsigned SUM_W    = IN_W + 4;
  localparam int unsigned ACC_W    = SUM_W + ACT_BITS;
  // Plane counter must reach ACT_BITS (one past the last plane) during DRAIN.
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned PLANE_W  = 3;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrain,
    StHold
  } state_e;

endpackage

// File: rtl/mac_accumulator_adder_tree16.sv
// 16-input adder tree with a single registered output and asynchronous clear.
module mac_accumulator_adder_tree16
  import mac_accumulator_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_BANK*IN_W-1:0] add_i,
  output logic [SUM_W-1:0]         sum_o
);

  logic [SUM_W-1:0] lvl1_s [8];
  logic [SUM_W-1:0] lvl2_s [4];
  logic [SUM_W-1:0] lvl3_s [2];
  logic [SUM_W-1:0] sum_d;
  logic [SUM_W-1:0] sum_q;

  // Balanced pairwise reduction, zero-extended at every level.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      lvl1_s[i] = SUM_W'(add_i[(2*i)*IN_W +: IN_W]) + SUM_W'(add_i[(2*i+1)*IN_W +: IN_W]);
    end
    for (int i = 0; i < 4; i++) begin
      lvl2_s[i] = lvl1_s[2*i] + lvl1_s[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      lvl3_s[i] = lvl2_s[2*i] + lvl2_s[2*i+1];
    end
    sum_d = lvl3_s[0] + lvl3_s[1];
  end

  // Output register: holds the sum of the inputs seen at the previous edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mac_accumulator.sv
// Bit-serial MAC / match-count accumulator fed by 16 bank partial products.
// Drives plane_idx to the upstream controller, shift-accumulates the registered
// tree sum one plane behind, and returns the result over valid/ready.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter bit ACT_SIGNED = 1'b0
) (
  input  logic               clk_inv,
  input  logic               rst,
  input  logic               start,
  input  logic               mac_en,
  input  logic [IN_W-1:0]    add0,
  input  logic [IN_W-1:0]    add1,
  input  logic [IN_W-1:0]    add2,
  input  logic [IN_W-1:0]    add3,
  input  logic [IN_W-1:0]    add4,
  input  logic [IN_W-1:0]    add5,
  input  logic [IN_W-1:0]    add6,
  input  logic [IN_W-1:0]    add7,
  input  logic [IN_W-1:0]    add8,
  input  logic [IN_W-1:0]    add9,
  input  logic [IN_W-1:0]    add10,
  input  logic [IN_W-1:0]    add11,
  input  logic [IN_W-1:0]    add12,
  input  logic [IN_W-1:0]    add13,
  input  logic [IN_W-1:0]    add14,
  input  logic [IN_W-1:0]    add15,
  output logic [PLANE_W-1:0] plane_idx,
  output logic               busy,
  output logic [ACC_W-1:0]   result,
  output logic               result_valid,
  input  logic               result_ready
);

  logic [NUM_BANK*IN_W-1:0] add_flat;
  logic [SUM_W-1:0]         tree_sum;

  state_e               state_q, state_d;
  logic                 mac_q, mac_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PLANE_W-1:0]   plane_idx_q, plane_idx_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [ACC_W-1:0]     acc_q, acc_d;

  logic [CNT_W-1:0]     cnt_last;
  logic [PLANE_W-1:0]   acc_plane;
  logic [ACC_W-1:0]     term;
  logic                 term_neg;
  logic [ACC_W-1:0]     acc_next;

  assign add_flat = {add15, add14, add13, add12, add11, add10, add9, add8,
                     add7, add6, add5, add4, add3, add2, add1, add0};

  mac_accumulator_adder_tree16 u_tree (
    .clk_i (clk_inv),
    .rst_i (rst),
    .add_i (add_flat),
    .sum_o (tree_sum)
  );

  // Plane arithmetic: tree_q always holds plane cnt_q-1 while accumulating.
  always_comb begin
    cnt_last  = mac_q ? CNT_W'(ACT_BITS - 1) : '0;
    acc_plane = PLANE_W'(cnt_q - CNT_W'(1));
    term      = ACC_W'(tree_sum) << acc_plane;
    term_neg  = ACT_SIGNED && mac_q && (acc_plane == PLANE_W'(ACT_BITS - 1));
    acc_next  = term_neg ? (acc_q - term) : (acc_q + term);
  end

  // Next-state logic for the FSM, plane counters and accumulator.
  always_comb begin
    state_d     = state_q;
    mac_d       = mac_q;
    cnt_d       = cnt_q;
    plane_idx_d = plane_idx_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    acc_d       = acc_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StFill;
          mac_d       = mac_en;
          cnt_d       = '0;
          plane_idx_d = '0;
          acc_d       = '0;
          busy_d      = 1'b1;
        end
      end
      StFill: begin
        // First FILL edge only loads the tree; nothing valid to add yet.
        if (cnt_q != '0) begin
          acc_d = acc_next;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (plane_idx_q != PLANE_W'(cnt_last)) begin
          plane_idx_d = plane_idx_q + PLANE_W'(1);
        end
        if (cnt_q == cnt_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        acc_d   = acc_next;
        valid_d = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (result_ready) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
    endcase
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk_inv or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mac_q       <= 1'b0;
      cnt_q       <= '0;
      plane_idx_q <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      mac_q       <= mac_d;
      cnt_q       <= cnt_d;
      plane_idx_q <= plane_idx_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      acc_q       <= acc_d;
    end
  end

  assign plane_idx    = plane_idx_q;
  assign busy         = busy_q;
  assign result       = acc_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench: unsigned and signed instances share one stimulus stream.
module tb_mac_accumulator;

  logic       clk_inv = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mac_en = 1'b0;
  logic       result_ready = 1'b0;
  logic [7:0] add [16];

  logic [2:0]  plane_u, plane_s;
  logic        busy_u, busy_s;
  logic [19:0] result_u, result_s;
  logic        valid_u, valid_s;

  int errors = 0;
  int checks = 0;

  logic [7:0] pl [8][16];

  typedef struct {
    bit          mac;
    logic [7:0]  val;
    logic [15:0] banks;
    logic [7:0]  planes;
    logic [19:0] exp_u;
    logic [19:0] exp_s;
    int          stall;
  } vec_t;

  vec_t tbl [6];

  always #5 clk_inv = ~clk_inv;

  mac_accumulator #(.ACT_SIGNED(1'b0)) dut_u (
    .clk_inv(clk_inv), .rst(rst), .start(start), .mac_en(mac_en),
    .add0(add[0]), .add1(add[1]), .add2(add[2]), .add3(add[3]),
    .add4(add[4]), .add5(add[5]), .add6(add[6]), .add7(add[7]),
    .add8(add[8]), .add9(add[9]), .add10(add[10]), .add11(add[11]),
    .add12(add[12]), .add13(add[13]), .add14(add[14]), .add15(add[15]),
    .plane_idx(plane_u), .busy(busy_u), .result(result_u),
    .result_valid(valid_u), .result_ready(result_ready)
  );

  mac_accumulator #(.ACT_SIGNED(1'b1)) dut_s (
    .clk_inv(clk_inv), .rst(rst), .start(start), .mac_en(mac_en),
    .add0(add[0]), .add1(add[1]), .add2(add[2]), .add3(add[3]),
    .add4(add[4]), .add5(add[5]), .add6(add[6]), .add7(add[7]),
    .add8(add[8]), .add9(add[9]), .add10(add[10]), .add11(add[11]),
    .add12(add[12]), .add13(add[13]), .add14(add[14]), .add15(add[15]),
    .plane_idx(plane_s), .busy(busy_s), .result(result_s),
    .result_valid(valid_s), .result_ready(result_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_inv);
    #1;
  endtask

  task automatic zero_inputs();
    for (int b = 0; b < 16; b++) add[b] = 8'h00;
  endtask

  // Reference: weighted sum of per-plane totals, MSB plane negative if signed MAC.
  function automatic logic [19:0] model(input bit mac, input bit signed_act);
    longint acc = 0;
    int n = mac ? 8 : 1;
    for (int p = 0; p < n; p++) begin
      longint s = 0;
      for (int b = 0; b < 16; b++) s += longint'(pl[p][b]);
      if (signed_act && mac && p == 7) acc -= s * (longint'(1) << p);
      else acc += s * (longint'(1) << p);
    end
    return acc[19:0];
  endfunction

  task automatic fill_from(input vec_t v);
    for (int p = 0; p < 8; p++)
      for (int b = 0; b < 16; b++)
        pl[p][b] = (v.planes[p] && v.banks[b]) ? v.val : 8'h00;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ":plane"}, plane_u, 0);
    chk({tag, ":busy"}, busy_u, 0);
    chk({tag, ":result"}, result_u, 0);
    chk({tag, ":valid"}, valid_u, 0);
    chk({tag, ":valid_s"}, valid_s, 0);
  endtask

  // One full operation: plane-by-plane drive, latency, result, backpressure.
  task automatic run_op(input string tag, input bit mac, input int stall, input bit poke_fill,
                        input logic [19:0] exp_u, input logic [19:0] exp_s);
    int n = mac ? 8 : 1;
    start  = 1'b1;
    mac_en = mac;
    step();
    start  = 1'b0;
    mac_en = ~mac;  // must be ignored after the accepted start
    chk({tag, ":busy_start"}, busy_u, 1);
    for (int k = 0; k < n; k++) begin
      chk({tag, ":plane_seq"}, plane_u, k);
      chk({tag, ":early_valid"}, valid_u, 0);
      for (int b = 0; b < 16; b++) add[b] = pl[k][b];
      start = (poke_fill && k == 2) ? 1'b1 : 1'b0;
      step();
    end
    start = 1'b0;
    zero_inputs();
    chk({tag, ":valid_drain"}, valid_u, 0);
    step();
    chk({tag, ":valid_rise"}, valid_u, 1);
    chk({tag, ":valid_rise_s"}, valid_s, 1);
    chk({tag, ":result_u"}, result_u, exp_u);
    chk({tag, ":result_s"}, result_s, exp_s);
    chk({tag, ":plane_sat"}, plane_u, n - 1);
    for (int i = 0; i < stall; i++) begin
      start = (i == 1) ? 1'b1 : 1'b0;
      step();
      start = 1'b0;
      chk({tag, ":hold_valid"}, valid_u, 1);
      chk({tag, ":hold_busy"}, busy_u, 1);
      chk({tag, ":hold_result"}, result_u, exp_u);
    end
    // start in the handshake cycle must not launch a new operation
    result_ready = 1'b1;
    start        = 1'b1;
    step();
    result_ready = 1'b0;
    start        = 1'b0;
    chk({tag, ":valid_drop"}, valid_u, 0);
    chk({tag, ":busy_drop"}, busy_u, 0);
    step();
    chk({tag, ":stays_idle"}, busy_u, 0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'd1,   16'h001F, 8'h01, 20'h00005, 20'h00005, 0};
    tbl[1] = '{1'b1, 8'hFF,  16'hFFFF, 8'hFF, 20'hFE010, 20'hFF010, 5};
    tbl[2] = '{1'b1, 8'd10,  16'h0001, 8'h80, 20'h00500, 20'hFFB00, 0};
    tbl[3] = '{1'b1, 8'd3,   16'hFFFF, 8'h81, 20'h01830, 20'hFE830, 1};
    tbl[4] = '{1'b0, 8'hFF,  16'hFFFF, 8'h01, 20'h00FF0, 20'h00FF0, 0};
    tbl[5] = '{1'b1, 8'd1,   16'h0001, 8'h01, 20'h00001, 20'h00001, 2};

    zero_inputs();
    #2 rst = 1'b1;
    #10;
    check_idle("reset");
    @(negedge clk_inv);
    rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      fill_from(tbl[i]);
      run_op($sformatf("vec%0d", i), tbl[i].mac, tbl[i].stall, 1'b0, tbl[i].exp_u, tbl[i].exp_s);
    end

    // start re-pulsed during FILL must not disturb the plane sequence
    fill_from(tbl[1]);
    run_op("refill", 1'b1, 0, 1'b1, 20'hFE010, 20'hFF010);

    // reset mid-operation at plane_idx 3
    fill_from(tbl[1]);
    start  = 1'b1;
    mac_en = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int b = 0; b < 16; b++) add[b] = pl[k][b];
      step();
    end
    chk("midrst:plane3", plane_u, 3);
    rst = 1'b1;
    #1;
    check_idle("midrst");
    step();
    rst = 1'b0;
    zero_inputs();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("midrst:no_valid", valid_u, 0);
    end
    run_op("after_rst", 1'b1, 0, 1'b0, 20'hFE010, 20'hFF010);

    // randomized operations against the arithmetic model
    for (int r = 0; r < 20; r++) begin
      bit mac = 1'($urandom_range(0, 1));
      for (int p = 0; p < 8; p++)
        for (int b = 0; b < 16; b++)
          pl[p][b] = mac ? 8'($urandom) : 8'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", r), mac, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             model(mac, 1'b0), model(mac, 1'b1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
